// File: rtl/instruction_loader.sv
// instruction_loader: streams host words into the instruction memory
// external write port at sequential field addresses, one word per cycle.
//
// Ports:
//   clk, reset (async, active-low)
//   start, num_words, abort      : load request / cancel from controller
//   s_valid, s_data, s_ready     : host word stream (valid/ready)
//   wr_en/addr/data_ext_im       : registered instruction memory write port
//   busy, done, error            : status (done/error are one-cycle pulses)
//   checksum                     : wrapping word sum, only when
//                                  INSTR_LOADER_CHECKSUM_EN is defined,
//                                  otherwise tied to 0
module instruction_loader #(
    parameter int BIT_WIDTH_EXTERNAL_PORT = 32,
    parameter int IM_SIZE                 = 2,
    parameter int IM_FIELDS               = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [31:0]                        num_words,
    input  logic                               abort,
    input  logic                               s_valid,
    input  logic [31:0]                        s_data,
    output logic                               s_ready,
    output logic                               wr_en_ext_im,
    output logic [BIT_WIDTH_EXTERNAL_PORT-1:0] wr_addr_ext_im,
    output logic [BIT_WIDTH_EXTERNAL_PORT-1:0] wr_data_ext_im,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic [31:0]                        checksum
);

    localparam logic [31:0] CAP = 32'(IM_SIZE * IM_FIELDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] count;
    logic [31:0] words;
    logic        hs;
    logic        last;
    logic        req_ok;
    logic        accept;

    // A handshake that coincides with abort is dropped entirely.
    assign hs     = s_valid && (state == LOAD) && !abort;
    assign last   = (count == words - 32'd1);
    assign req_ok = (num_words != 32'd0) && (num_words <= CAP);
    assign accept = (state == IDLE) && start && req_ok;

    assign s_ready = (state == LOAD);
    assign busy    = (state == LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            count          <= '0;
            words          <= '0;
            wr_en_ext_im   <= 1'b0;
            wr_addr_ext_im <= '0;
            wr_data_ext_im <= '0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            wr_en_ext_im <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (req_ok) begin
                            words <= num_words;
                            count <= '0;
                            state <= LOAD;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (hs) begin
                        wr_en_ext_im   <= 1'b1;
                        wr_addr_ext_im <= BIT_WIDTH_EXTERNAL_PORT'(count);
                        wr_data_ext_im <= BIT_WIDTH_EXTERNAL_PORT'(s_data);
                        count          <= count + 32'd1;
                        if (last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (hs) begin
            sum_q <= sum_q + s_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: expected writes are queued at
// each handshake and matched (addr, data, cycle) by a write monitor.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] num_words = '0;
    logic        abort = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic        wr_en_ext_im;
    logic [31:0] wr_addr_ext_im;
    logic [31:0] wr_data_ext_im;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t q[$];

    instruction_loader #(
        .BIT_WIDTH_EXTERNAL_PORT(32),
        .IM_SIZE(2),
        .IM_FIELDS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_words(num_words),
        .abort(abort),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .wr_en_ext_im(wr_en_ext_im),
        .wr_addr_ext_im(wr_addr_ext_im),
        .wr_data_ext_im(wr_data_ext_im),
        .busy(busy),
        .done(done),
        .error(error),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word offered for one edge; the handshake is expected to be taken.
    task automatic send(input logic [31:0] data, input logic [31:0] addr);
        wr_t e;
        s_valid = 1'b1;
        s_data  = data;
        tick();
        e.addr = addr;
        e.data = data;
        e.cyc  = cyc;
        q.push_back(e);
        s_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (wr_en_ext_im === 1'b1) begin
            chk("write_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", wr_addr_ext_im, e.addr);
                chk("wr_data", wr_data_ext_im, e.data);
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    logic [31:0] bad_n [2];

    initial begin
        bad_n[0] = 32'd0;
        bad_n[1] = 32'd5;

        #3;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en_ext_im), 32'd0);
        chk("rst_wr_addr", wr_addr_ext_im, 32'd0);
        chk("rst_wr_data", wr_data_ext_im, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // 4 words back-to-back
        start = 1'b1;
        num_words = 32'd4;
        tick();
        start = 1'b0;
        chk("s1_busy", 32'(busy), 32'd1);
        chk("s1_s_ready", 32'(s_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send(32'hA0 + 32'(i), 32'(i));
        end
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_busy_end", 32'(busy), 32'd0);
        chk("s1_s_ready_end", 32'(s_ready), 32'd0);
        chk("s1_checksum", checksum, CK_EN ? 32'h286 : 32'h0);
        tick();
        chk("s1_done_pulse", 32'(done), 32'd0);
        chk("s1_drained", 32'(q.size()), 32'd0);

        // rejected requests
        for (int k = 0; k < 2; k++) begin
            start = 1'b1;
            num_words = bad_n[k];
            s_valid = 1'b1;
            tick();
            start = 1'b0;
            chk("s2_error", 32'(error), 32'd1);
            chk("s2_busy", 32'(busy), 32'd0);
            tick();
            chk("s2_error_pulse", 32'(error), 32'd0);
            chk("s2_busy2", 32'(busy), 32'd0);
            s_valid = 1'b0;
        end

        // gapped valid
        start = 1'b1;
        num_words = 32'd3;
        tick();
        start = 1'b0;
        send(32'hB0, 32'd0);
        tick();
        send(32'hB1, 32'd1);
        tick();
        chk("s3_idle_wr_en", 32'(wr_en_ext_im), 32'd0);
        chk("s3_hold_addr", wr_addr_ext_im, 32'd1);
        chk("s3_hold_data", wr_data_ext_im, 32'hB1);
        chk("s3_no_done", 32'(done), 32'd0);
        send(32'hB2, 32'd2);
        chk("s3_done", 32'(done), 32'd1);
        tick();
        chk("s3_drained", 32'(q.size()), 32'd0);

        // start during LOAD is ignored
        start = 1'b1;
        num_words = 32'd2;
        tick();
        num_words = 32'd1;
        send(32'hC0, 32'd0);
        start = 1'b0;
        chk("s4_busy", 32'(busy), 32'd1);
        chk("s4_no_done", 32'(done), 32'd0);
        chk("s4_no_error", 32'(error), 32'd0);
        send(32'hC1, 32'd1);
        chk("s4_done", 32'(done), 32'd1);
        tick();
        chk("s4_drained", 32'(q.size()), 32'd0);

        // abort on second handshake
        start = 1'b1;
        num_words = 32'd4;
        tick();
        start = 1'b0;
        send(32'hD0, 32'd0);
        s_valid = 1'b1;
        s_data = 32'hD1;
        abort = 1'b1;
        chk("s5_ready_abort", 32'(s_ready), 32'd1);
        tick();
        abort = 1'b0;
        s_valid = 1'b0;
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_s_ready", 32'(s_ready), 32'd0);
        chk("s5_no_done", 32'(done), 32'd0);
        tick();
        chk("s5_no_done2", 32'(done), 32'd0);
        chk("s5_drained", 32'(q.size()), 32'd0);
        start = 1'b1;
        num_words = 32'd2;
        tick();
        start = 1'b0;
        send(32'hFFFF_FFF0, 32'd0);
        send(32'h0000_0020, 32'd1);
        chk("s5_done", 32'(done), 32'd1);
        chk("s5_checksum", checksum, CK_EN ? 32'h10 : 32'h0);
        tick();
        chk("s5_drained2", 32'(q.size()), 32'd0);

        // reset mid-load
        start = 1'b1;
        num_words = 32'd4;
        tick();
        start = 1'b0;
        send(32'hF0, 32'd0);
        send(32'hF1, 32'd1);
        #6;
        reset = 1'b0;
        #1;
        chk("s6_wr_en", 32'(wr_en_ext_im), 32'd0);
        chk("s6_wr_addr", wr_addr_ext_im, 32'd0);
        chk("s6_wr_data", wr_data_ext_im, 32'd0);
        chk("s6_s_ready", 32'(s_ready), 32'd0);
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_checksum", checksum, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        s_valid = 1'b1;
        tick();
        tick();
        chk("s6_ready_after", 32'(s_ready), 32'd0);
        chk("s6_busy_after", 32'(busy), 32'd0);
        s_valid = 1'b0;
        tick();
        chk("s6_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
